// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
//   state_e       : receiver FSM state encoding (3-bit)
//   calc_divisor  : clocks per oversample tick, rounded to nearest
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
    } state_e;

    function automatic int unsigned calc_divisor(input int unsigned clock,
                                                 input int unsigned baud_rate,
                                                 input int unsigned oversample);
        return (clock + (baud_rate * oversample) / 2) / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_baud_rate_gen.sv
// Free-running oversample tick generator.
// Ports:
//   i_clock  in  system clock
//   i_reset  in  asynchronous active-low reset
//   o_tick   out one-cycle pulse every DIVISOR clocks
module baud_rate_gen
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLOCK      = 50_000_000,
    parameter int unsigned BAUD_RATE  = 19200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_tick
);

    localparam int unsigned Divisor = calc_divisor(CLOCK, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned CntW    = (Divisor > 1) ? $clog2(Divisor) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Divisor - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        o_tick = (cnt_q == CntLast);
        cnt_d  = o_tick ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 (parameterisable) UART receiver with oversampled bit-centre sampling.
// Ports:
//   i_clock         in  system clock
//   i_reset         in  asynchronous active-low reset
//   i_rx            in  serial line, idles high, asynchronous to i_clock
//   o_rx_data       out last received word, LSB first on the line
//   o_rx_done_tick  out one-cycle pulse on a frame with a valid stop bit
//   o_frame_error   out one-cycle pulse when the stop bit is sampled low
//   o_busy          out high while a frame is in progress
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLOCK      = 50_000_000,
    parameter int unsigned BAUD_RATE  = 19200,
    parameter int unsigned N_BITS     = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rx,
    output logic [N_BITS-1:0] o_rx_data,
    output logic              o_rx_done_tick,
    output logic              o_frame_error,
    output logic              o_busy
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(N_BITS - 1);

    logic tick;

    baud_rate_gen #(
        .CLOCK      (CLOCK),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_rate_gen (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .o_tick  (tick)
    );

    // Two-flop synchronizer; resets to the idle line level.
    logic rx_meta_q;
    logic rx_sync_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    state_e             state_q, state_d;
    logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [N_BITS-1:0]  shift_q, shift_d;
    logic [N_BITS-1:0]  data_q;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               load_data;

    // State and datapath registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            err_q      <= err_d;
            if (load_data) begin
                data_q <= shift_q;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        case (state_q)
            StIdle: begin
                if (!rx_sync_q) begin
                    state_d    = StStart;
                    tick_cnt_d = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (tick_cnt_q == TickHalf) begin
                        // High at mid start bit means a glitch, not a frame.
                        if (rx_sync_q) begin
                            state_d = StIdle;
                        end else begin
                            state_d    = StData;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_sync_q, shift_q[N_BITS-1:1]};
                        if (bit_cnt_q == BitLast) begin
                            state_d   = StStop;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BitW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        state_d    = rx_sync_q ? StIdle : StBreak;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            StBreak: begin
                // Hold off new frames until the line returns to idle.
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic; pulses are registered so they land one clock after the stop sample.
    always_comb begin
        load_data = (state_q == StStop) && tick && (tick_cnt_q == TickLast);
        done_d    = load_data && rx_sync_q;
        err_d     = load_data && !rx_sync_q;
    end

    assign o_rx_data      = data_q;
    assign o_rx_done_tick = done_q;
    assign o_frame_error  = err_q;
    assign o_busy         = (state_q != StIdle);

endmodule
